event_latch_server: RTL
=======================

Name: event_latch_server

Overview:
- Consumer-side counterpart to the asynchronous nor-based set/reset latches used for event and interrupt flags.
- Captures N single-cycle or level event requests into synchronous pending flags, using the same reset-dominant semantics as the nor latches.
- Arbitrates the flags by fixed priority and presents one event at a time to a downstream consumer (CPU-side IRQ logic, DMA sequencer) over a 4-phase req/ack handshake.
- Clears a flag only when the consumer acknowledges that specific flag.

Parameters:
- N, 4, number of event sources (2..16).
- EDGE, 1, 1: events are rising-edge detected; 0: events are level-sensitive (set every cycle while high).
- IDX_W, $clog2(N), width of the index bus (derived; do not override).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- res  in  1  synchronous, active-high reset.
- ev  in  N  event set inputs, bit i sets pending[i].
- clr  in  N  per-source clear; dominates ev for the same bit, as in the nor latch.
- mask  in  N  1 = source i is not eligible for presentation; it still latches.
- pending  out  N  current flag state (q of each latch).
- req  out  1  request to consumer.
- idx  out  IDX_W  index of the presented source; valid while req=1.
- ack  in  1  consumer acknowledge.
- busy  out  1  state != IDLE.

Behaviour:
- Reset. One clock, synchronous, active-high reset (res); polarity and synchronicity fixed.
- On res=1 at a clock edge:
  - pending=0, req=0, idx=0, busy=0.
  - State goes to IDLE and the edge-detect history register goes to 0.
  - Events present during that cycle are discarded.
  - Reset mid-handshake aborts silently. The consumer must tolerate req falling without its ack.
- Edge detect (EDGE=1). set_i = ev[i] & ~ev_d[i], where ev_d is registered ev. A held-high ev produces exactly one set.
- Flag update, per bit, each cycle:
  - pending_next = ~(clr | ack_clear) & (pending | set).
  - Clear beats set in the same cycle; the event is lost, matching nor-latch reset priority.
  - ack_clear = one-hot of idx when the FSM takes PRESENT->HOLD.
- Arbitration. Eligible = pending & ~mask. Winner = lowest set index, fixed priority.
- FSM:
  - IDLE: if eligible != 0, register idx = winner, set req=1 and go to PRESENT. A flag set at edge k yields req=1 at edge k+1, i.e. 1-cycle latency from pending to req. A new event in cycle k gives pending at k+1 and req at k+2.
  - PRESENT: idx frozen.
    - If ack=1: clear pending[idx], req=0, go to HOLD.
    - Else if clr[idx]=1 or mask[idx]=1 (withdrawn): req=0, go to IDLE with no ack expected. Withdrawal is checked only when ack=0; ack wins.
    - Else stay in PRESENT.
  - HOLD: wait for ack=0, then go to IDLE. No new req is issued until ack is low (4-phase).
- Re-arm. A re-set of the same source while it is presented (set during PRESENT) is absorbed by the ack clear in the same cycle. A set arriving in HOLD or later re-latches normally.
- busy = (state != IDLE).
- Simultaneous events in one cycle: all latch; they are presented in ascending index order, one handshake each.
- ack=1 while in IDLE is ignored and has no effect on pending.
- All outputs are registered; no combinational path from ack or ev to req or idx.

Decomposition:
- Shared package (event_pkg): FSM state enum {IDLE, PRESENT, HOLD} (2 bits), and a priority-encoder function lowest_set(N-bit) -> {found, IDX_W index}.
- One sub-module: event_flag_bank. It holds the N synchronous flags, the edge detect and the clear/set priority. Inputs: ev, clr, ack_clear, res. Output: pending.
- The FSM and arbitration stay in the top module.

Test Plan:
1. Set with 1-cycle latency: res 2 cycles; ev=4'b0100 pulse at cycle 5 -> pending=0100 at 6, req=1 idx=2 at 7; ack at 9 -> pending=0000 and req=0 at 10; ack low at 11 -> IDLE at 12.
2. Priority order and 4-phase timing: ev=4'b1011 one cycle -> three handshakes with idx 0, 1, 3 in order; no req between ack-high and ack-low.
3. Clear dominance: ev[1]=1 and clr[1]=1 in the same cycle -> pending[1] stays 0, no req. With EDGE=1, ev[1] held high 10 cycles -> exactly one handshake.
4. Withdrawal: req idx=0 presented, then clr[0]=1 with ack=0 -> req=0 next cycle, state IDLE, pending=0. In a second run, mask[0]=1 during PRESENT -> req=0 and pending[0] stays 1; unmasking re-presents idx=0.
5. Reset mid-operation: in PRESENT with pending=0110, res=1 one cycle -> next cycle pending=0, req=0, busy=0; an ev pulse coincident with res is lost.
6. Stray ack and re-set: ack=1 in IDLE with pending=0 -> no change. ev[2] pulse while idx=2 is presented and acked in the same cycle -> pending[2]=0 afterward. ev[2] pulse during HOLD -> a second handshake with idx=2.

Source files
------------

// File: rtl/event_pkg.sv
// event_pkg: shared FSM state type and lowest-index priority encoder for the event latch server.
package event_pkg;
  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } sel_t;
  function automatic sel_t lowest_set(input logic [15:0] v);
    sel_t s;
    s = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) begin
        s.found = 1'b1;
        s.idx   = 4'(i);
      end
    return s;
  endfunction
endpackage

// File: rtl/event_flag_bank.sv
// event_flag_bank: N synchronous set/reset flags with optional edge detect and clear-dominant update.
module event_flag_bank #(
  parameter int N    = 4,
  parameter bit EDGE = 1
) (
  input  logic         clk,
  input  logic         res,
  input  logic [N-1:0] ev,
  input  logic [N-1:0] clr,
  input  logic [N-1:0] ack_clear,
  output logic [N-1:0] pending
);
  logic [N-1:0] r_ev_d, r_pending, w_set;
  assign w_set   = EDGE ? ev & ~r_ev_d : ev;
  assign pending = r_pending;
  always_ff @(posedge clk) begin
    if (res) begin
      r_pending <= '0;
      r_ev_d    <= '0;
    end else begin
      r_pending <= ~(clr | ack_clear) & (r_pending | w_set);
      r_ev_d    <= ev;
    end
  end
endmodule

// File: rtl/event_latch_server.sv
// event_latch_server: latches event flags and serves them by fixed priority over a 4-phase req/ack handshake.
module event_latch_server
  import event_pkg::*;
#(
  parameter  int N     = 4,
  parameter  bit EDGE  = 1,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             res,
  input  logic [N-1:0]     ev,
  input  logic [N-1:0]     clr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pending,
  output logic             req,
  output logic [IDX_W-1:0] idx,
  input  logic             ack,
  output logic             busy
);
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx, w_next_idx;
  logic             r_req;
  logic [N-1:0]     w_ack_clear;
  sel_t             w_sel;
  event_flag_bank #(.N(N), .EDGE(EDGE)) u_bank (
    .clk(clk), .res(res), .ev(ev), .clr(clr), .ack_clear(w_ack_clear), .pending(pending)
  );
  assign w_sel       = lowest_set(16'(pending & ~mask));
  assign w_ack_clear = (r_state == PRESENT && ack) ? N'(1) << r_idx : '0;
  always_comb begin
    w_next     = r_state;
    w_next_idx = r_idx;
    if (r_state == IDLE && w_sel.found) begin
      w_next     = PRESENT;
      w_next_idx = IDX_W'(w_sel.idx);
    end
    if (r_state == PRESENT)
      w_next = ack ? HOLD : (clr[r_idx] || mask[r_idx]) ? IDLE : PRESENT;
    if (r_state == HOLD)
      w_next = ack ? HOLD : IDLE;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_next_idx;
      r_req   <= (w_next == PRESENT);
    end
  end
  assign req  = r_req;
  assign idx  = r_idx;
  assign busy = (r_state != IDLE);
endmodule
